// File: rtl/instruction_fetch_stage.sv
// RISC-V fetch stage: PC register, req/ack instruction-memory fetch, valid/ready hand-off to decode.
// Optional misaligned-redirect trap is enabled by defining IFETCH_MISALIGN_TRAP_EN.
module instruction_fetch_stage #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_fault
);

  localparam logic [31:0]     NOP_INSN = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(2'b11);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
`ifdef IFETCH_MISALIGN_TRAP_EN
    S_FAULT = 3'd4,
`endif
    S_VALID = 3'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_req_addr, w_req_nxt;
  logic [31:0]     r_instr, w_instr_nxt;
  logic [XLEN-1:0] r_id_pc, w_id_pc_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_redir_go;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic            w_redir_trap;
  logic            r_fault, w_fault_nxt;
  logic            r_pend, w_pend_nxt;

  // A misaligned target is trapped rather than loaded.
  always_comb begin
    w_redir_pc   = redirect_pc;
    w_redir_trap = redirect_valid & (|redirect_pc[1:0]);
    w_redir_go   = redirect_valid & ~(|redirect_pc[1:0]);
  end
  assign fetch_fault = r_fault;
`else
  // Without the trap, the low target bits are simply cleared.
  always_comb begin
    w_redir_pc = redirect_pc & ~LOW_MASK;
    w_redir_go = redirect_valid;
  end
  assign fetch_fault = 1'b0;
`endif

  assign imem_req       = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr      = r_req_addr;
  assign id_valid       = (r_state == S_VALID);
  assign id_instruction = r_instr;
  assign id_pc          = r_id_pc;

  // Next-state and datapath update; redirect has priority over ack and ready.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_req_addr;
    w_instr_nxt = r_instr;
    w_id_pc_nxt = r_id_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
    w_fault_nxt = r_fault;
    w_pend_nxt  = r_pend;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_req_nxt   = r_pc;
      end
      S_FETCH: begin
        if (w_redir_go) begin
          w_pc_nxt = w_redir_pc;
          if (imem_ack) begin
            w_req_nxt   = w_redir_pc;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        else if (w_redir_trap) begin
          w_fault_nxt = 1'b1;
          if (imem_ack) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_pend_nxt  = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end
`endif
        else if (imem_ack) begin
          w_instr_nxt = imem_rdata;
          w_id_pc_nxt = r_req_addr;
          w_pc_nxt    = r_req_addr + PC_STEP;
          w_state_nxt = S_VALID;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (w_redir_go) begin
          w_pc_nxt = w_redir_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
          w_pend_nxt  = 1'b0;
          w_fault_nxt = 1'b0;
        end else if (w_redir_trap) begin
          w_pend_nxt  = 1'b1;
          w_fault_nxt = 1'b1;
`endif
        end else begin
          w_pc_nxt = r_pc;
        end
        // The old request completes here; its data is thrown away.
        if (imem_ack) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (w_pend_nxt) begin
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_FAULT;
          end else
`endif
          begin
            w_req_nxt   = w_pc_nxt;
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_VALID: begin
        if (w_redir_go) begin
          w_pc_nxt    = w_redir_pc;
          w_req_nxt   = w_redir_pc;
          w_state_nxt = S_FETCH;
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        else if (w_redir_trap) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = S_FAULT;
        end
`endif
        else if (id_ready) begin
          w_req_nxt   = r_pc;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_VALID;
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      S_FAULT: begin
        if (w_redir_go) begin
          w_pc_nxt    = w_redir_pc;
          w_req_nxt   = w_redir_pc;
          w_fault_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_instr    <= NOP_INSN;
      r_id_pc    <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
      r_pend     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_nxt;
      r_instr    <= w_instr_nxt;
      r_id_pc    <= w_id_pc_nxt;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_fault    <= w_fault_nxt;
      r_pend     <= w_pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: table-driven fetches plus redirect, wrap,
// misaligned-target and asynchronous-reset sequences, with a scoreboard of expected instructions.
module tb_instruction_fetch_stage;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instruction;
  logic [XLEN-1:0] id_pc;
  logic            fetch_fault;

  instruction_fetch_stage #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instruction(id_instruction), .id_pc(id_pc),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          stall;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   checks;
  int   failures;
  logic [63:0] model_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the decode-side outputs against the oldest scoreboard entry.
  task automatic chk_head(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=empty_scoreboard expected=entry", name);
    end else begin
      e = sb[0];
      chk({name, "_pc"}, id_pc, e.pc);
      chk({name, "_ins"}, {32'h0, id_instruction}, {32'h0, e.ins});
    end
  endtask

  // Called in FETCH: wait lat cycles with the address held, then ack with data.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data, input int lat);
    exp_t e;
    chk("req_on", imem_req, 1'b1);
    chk("req_addr", imem_addr, addr);
    for (int k = 0; k < lat; k++) begin
      tick();
      chk("req_wait", imem_req, 1'b1);
      chk("addr_hold", imem_addr, addr);
      chk("no_valid_wait", id_valid, 1'b0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    e.pc  = addr;
    e.ins = data;
    sb.push_back(e);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("valid_on", id_valid, 1'b1);
    chk("req_off", imem_req, 1'b0);
    chk_head("valid_data");
  endtask

  // Decode accepts the presented instruction.
  task automatic accept();
    exp_t e;
    chk("acc_valid", id_valid, 1'b1);
    chk_head("acc");
    if (sb.size() != 0) e = sb.pop_front();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("valid_drop", id_valid, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{rdata: 32'h0020_0013, lat: 0, stall: 0};
    vecs[1] = '{rdata: 32'h0030_0093, lat: 2, stall: 5};
    vecs[2] = '{rdata: 32'h00a0_0113, lat: 1, stall: 1};
    vecs[3] = '{rdata: 32'hfff0_0193, lat: 0, stall: 0};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; id_ready = 1'b0;
    #23;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_ins", {32'h0, id_instruction}, 64'h13);
    chk("rst_pc", id_pc, 64'h0);
    chk("rst_fault", fetch_fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req", imem_req, 1'b0);
    tick();

    model_pc = 64'h0;
    for (int i = 0; i < 4; i++) begin
      do_fetch(model_pc, vecs[i].rdata, vecs[i].lat);
      for (int s = 0; s < vecs[i].stall; s++) begin
        id_ready = 1'b0;
        tick();
        chk("stall_valid", id_valid, 1'b1);
        chk("stall_req", imem_req, 1'b0);
        chk_head("stall");
      end
      accept();
      model_pc = model_pc + 64'd4;
    end

    // Redirect while the fetch at 0x10 waits for its ack.
    chk("seq_addr", imem_addr, 64'h10);
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("drain_req", imem_req, 1'b1);
      chk("drain_addr", imem_addr, 64'h10);
      chk("drain_valid", id_valid, 1'b0);
      if (k < 2) tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    imem_ack = 1'b0;
    chk("drain_discard", id_valid, 1'b0);
    do_fetch(64'h100, 32'h0000_0033, 0);

    // Redirect coinciding with id_ready drops the presented instruction.
    redirect_valid = 1'b1; redirect_pc = 64'h40; id_ready = 1'b1;
    void'(sb.pop_front());
    tick();
    redirect_valid = 1'b0; id_ready = 1'b0;
    chk("redir_valid_drop", id_valid, 1'b0);
    do_fetch(64'h40, 32'h0010_0073, 1);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    void'(sb.pop_front());
    tick();
    redirect_valid = 1'b0;
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0050_0293, 0);
    accept();
    chk("wrap_addr", imem_addr, 64'h0);

    // Misaligned redirect coinciding with an ack in FETCH.
    redirect_valid = 1'b1; redirect_pc = 64'h102; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("trap_fault", fetch_fault, 1'b1);
    chk("trap_req", imem_req, 1'b0);
    chk("trap_valid", id_valid, 1'b0);
    tick();
    chk("trap_hold", fetch_fault, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    chk("trap_clear", fetch_fault, 1'b0);
    do_fetch(64'h200, 32'h0000_0093, 0);
`else
    chk("mis_fault", fetch_fault, 1'b0);
    do_fetch(64'h100, 32'h0000_0093, 0);
`endif
    accept();

    // Asynchronous reset mid-request, between clock edges.
    chk("pre_rst_req", imem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_valid", id_valid, 1'b0);
    chk("arst_addr", imem_addr, 64'h0);
    chk("arst_pc", id_pc, 64'h0);
    chk("arst_ins", {32'h0, id_instruction}, 64'h13);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
